// File: rtl/mealy_match_logger.sv
// mealy_match_logger: timestamps each detector match as the cycle gap since
// the previous match, queues the gaps in a small FIFO drained over
// valid/ready, and keeps a running match count and a sticky overflow flag.
module mealy_match_logger #(
    parameter int DEPTH = 4,
    parameter int GAP_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     z,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [GAP_W-1:0]         evt_gap,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         match_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [GAP_W-1:0] mem [DEPTH];
    logic [GAP_W-1:0] g;
    logic [GAP_W-1:0] gap_next;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // FIFO status, push/pop qualification and saturating gap increment
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop      = !clr && !empty && evt_ready;
        // a pop on the same edge frees the slot, so a full FIFO still accepts
        push     = !clr && z && (!full || pop);
        gap_next = (g == GAP_MAX) ? GAP_MAX : g + 1'b1;
    end

    // Pointers, gap counter, match counter and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            g           <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            g           <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            g <= z ? '0 : gap_next;
            if (z) match_count <= match_count + 1'b1;
            if (z && !push) overflow <= 1'b1;
        end
    end

    // Gap storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= gap_next;
    end

    // Outputs are derived only from registered pointers and storage
    always_comb begin
        evt_valid = !empty;
        evt_gap   = empty ? '0 : mem[rd_ptr[AW-1:0]];
        level     = wr_ptr - rd_ptr;
    end

endmodule

// File: tb/tb_mealy_match_logger.sv
// Directed bench for mealy_match_logger; expected gaps are queued when a
// match is driven and compared as entries are drained.
module tb_mealy_match_logger;

    localparam int DEPTH = 4;
    localparam int GAP_W = 4;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             z = 1'b0;
    logic             evt_ready = 1'b0;
    logic             evt_valid;
    logic [GAP_W-1:0] evt_gap;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] match_count;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    mealy_match_logger #(
        .DEPTH(DEPTH),
        .GAP_W(GAP_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .z(z),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_gap(evt_gap),
        .level(level),
        .match_count(match_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic expect_push(input int gap);
        exp_q.push_back(gap);
    endtask

    task automatic check_head(input string tag);
        int e;
        check({tag, "_valid"}, evt_valid, 1);
        check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_gap"}, evt_gap, e);
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_head(tag);
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid0"}, evt_valid, 0);
        check({tag, "_gap0"}, evt_gap, 0);
        check({tag, "_level0"}, level, 0);
    endtask

    initial begin
        // reset state
        tick();
        check_empty("rst");
        check("rst_count", match_count, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;

        // spacing: matches on edges 5, 7, 9
        repeat (4) tick();
        z = 1'b1;
        #1;
        check("comb_valid", evt_valid, 0);
        check("comb_level", level, 0);
        expect_push(5);
        tick();
        z = 1'b0;
        tick();
        z = 1'b1;
        expect_push(2);
        tick();
        z = 1'b0;
        tick();
        z = 1'b1;
        expect_push(2);
        tick();
        z = 1'b0;
        check("sp_level", level, 3);
        check("sp_count", match_count, 3);
        drain("sp", 3);
        check_empty("sp_end");
        check("sp_ovf", overflow, 0);

        // reset mid-queue
        apply_reset();
        z = 1'b1;
        repeat (3) tick();
        z = 1'b0;
        check("rq_level_pre", level, 3);
        check("rq_count_pre", match_count, 3);
        rst = 1'b1;
        #1;
        check_empty("rq");
        check("rq_count", match_count, 0);
        check("rq_ovf", overflow, 0);
        rst = 1'b0;

        // overflow: 2 idle edges, then 6 consecutive matches
        tick();
        tick();
        z = 1'b1;
        expect_push(3);
        expect_push(1);
        expect_push(1);
        expect_push(1);
        repeat (6) tick();
        z = 1'b0;
        check("ov_level", level, 4);
        check("ov_count", match_count, 6);
        check("ov_flag", overflow, 1);
        drain("ov", 4);
        check("ov_sticky", overflow, 1);
        check_empty("ov_end");
        rst = 1'b1;
        #1;
        check("ov_rst", overflow, 0);
        rst = 1'b0;
        exp_q.delete();

        // full FIFO with simultaneous push and pop
        tick();
        z = 1'b1;
        expect_push(2);
        tick();
        expect_push(1);
        tick();
        z = 1'b0;
        tick();
        z = 1'b1;
        expect_push(2);
        tick();
        expect_push(1);
        tick();
        z = 1'b0;
        check("fp_level_pre", level, 4);
        check("fp_ovf_pre", overflow, 0);
        tick();
        check_head("fp_head");
        z = 1'b1;
        evt_ready = 1'b1;
        expect_push(2);
        tick();
        z = 1'b0;
        evt_ready = 1'b0;
        check("fp_level", level, 4);
        check("fp_ovf", overflow, 0);
        check("fp_count", match_count, 5);
        drain("fp", 4);
        check_empty("fp_end");

        // gap saturation, with a push into an empty FIFO while ready is high
        apply_reset();
        repeat (20) tick();
        z = 1'b1;
        evt_ready = 1'b1;
        expect_push(15);
        tick();
        z = 1'b0;
        evt_ready = 1'b0;
        check("sat_level", level, 1);
        check("sat_gap", evt_gap, 15);
        tick();
        tick();
        z = 1'b1;
        expect_push(3);
        tick();
        z = 1'b0;
        check("sat_level2", level, 2);
        drain("sat", 2);
        check_empty("sat_end");

        // clr with z and evt_ready on the same edge
        apply_reset();
        z = 1'b1;
        repeat (4) expect_push(1);
        repeat (5) tick();
        z = 1'b0;
        check("clr_ovf_pre", overflow, 1);
        check("clr_count_pre", match_count, 5);
        drain("clr_pre", 2);
        check("clr_level_pre", level, 2);
        clr = 1'b1;
        z = 1'b1;
        evt_ready = 1'b1;
        tick();
        clr = 1'b0;
        z = 1'b0;
        evt_ready = 1'b0;
        exp_q.delete();
        check_empty("clr");
        check("clr_count", match_count, 0);
        check("clr_ovf", overflow, 0);
        repeat (3) tick();
        z = 1'b1;
        expect_push(4);
        tick();
        z = 1'b0;
        check("clr_level_post", level, 1);
        check("clr_count_post", match_count, 1);
        drain("clr_post", 1);
        check_empty("clr_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
